// File: rtl/bus_arb_pkg.sv
// Shared constants, state encoding and priority helper for the 16-source
// round-robin bus arbiter.
package bus_arb_pkg;

    localparam int N_REQ        = 16;
    localparam int IDX_W        = 4;
    localparam int HOLD_W       = 4;
    localparam int HOLD_MAX_MIN = 1;
    localparam int HOLD_MAX_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

    // Index of the lowest set bit; zero when nothing is set.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_REQ-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority pick: first set request at or above ptr, wrapping 15 -> 0.
module rr_priority_pick
    import bus_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N_REQ-1:0] upper_mask;
    logic [N_REQ-1:0] upper_req;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
            assign upper_mask[gi] = (IDX_W'(gi) >= ptr);
        end
    endgenerate

    // Requests at or above ptr win; otherwise wrap to the lowest request overall.
    always_comb begin
        upper_req = req & upper_mask;
        any       = |req;
        idx       = (|upper_req) ? lowest_set(upper_req) : lowest_set(req);
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: IDLE picks an owner, OWNED holds it (bounded when
// others wait), TURN inserts a one-cycle gap before the next decision.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [N_REQ-1:0] req,
    // "release" is a reserved word, so the owner-finished strobe is bus_release.
    input  logic             bus_release,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N_REQ-1:0] grant_onehot,
    output logic             busy
);

    localparam int HOLD_EFF = (HOLD_MAX < HOLD_MAX_MIN) ? HOLD_MAX_MIN :
                              (HOLD_MAX > HOLD_MAX_MAX) ? HOLD_MAX_MAX : HOLD_MAX;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_EFF - 1);

    arb_state_e        state_reg;
    arb_state_e        state_next;
    logic [IDX_W-1:0]  ptr_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [N_REQ-1:0]  owner_mask;
    logic              others_req;
    logic              owner_done;

    rr_priority_pick u_pick (
        .req (req),
        .ptr (ptr_reg),
        .idx (pick_idx),
        .any (pick_any)
    );

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign owner_mask[gi]   = (idx_reg == IDX_W'(gi));
            assign grant_onehot[gi] = grant_valid && owner_mask[gi];
        end
    endgenerate

    // Release, a dropped request and a forced hand-over all collapse into one exit.
    assign others_req = |(req & ~owner_mask);
    assign owner_done = bus_release || !req[idx_reg] ||
                        ((hold_cnt_reg == HOLD_LAST) && others_req);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (pick_any) state_next = ST_OWNED;
            ST_OWNED: if (owner_done) state_next = ST_TURN;
            ST_TURN:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Owner index only changes on an IDLE decision; ptr only on OWNED exit.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            ptr_reg      <= '0;
            idx_reg      <= '0;
            hold_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_any) begin
                        idx_reg      <= pick_idx;
                        hold_cnt_reg <= '0;
                    end
                end
                ST_OWNED: begin
                    if (owner_done) begin
                        ptr_reg <= idx_reg + IDX_W'(1);
                    end else if (hold_cnt_reg != HOLD_LAST) begin
                        hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        grant_valid = (state_reg == ST_OWNED);
        busy        = (state_reg != ST_IDLE);
        grant_idx   = idx_reg;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (HOLD_MAX=4): each driven cycle queues the
// outputs expected after the next rising edge; a monitor pops and compares.
module tb_bus_arbiter;

    logic        clock;
    logic        clear;
    logic [15:0] req;
    logic        bus_release;
    logic        grant_valid;
    logic [3:0]  grant_idx;
    logic [15:0] grant_onehot;
    logic        busy;

    typedef struct {
        int         step;
        logic       valid;
        logic [3:0] idx;
        logic       busy;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [15:0] exp_oh;
    int          checks   = 0;
    int          failures = 0;
    int          step_no  = 0;
    logic [3:0]  order[4];

    bus_arbiter #(.HOLD_MAX(4)) dut (
        .clock        (clock),
        .clear        (clear),
        .req          (req),
        .bus_release  (bus_release),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic [15:0] r, input logic rl,
                         input logic ev, input logic [3:0] ei, input logic eb);
        exp_t e;
        @(negedge clock);
        req         = r;
        bus_release = rl;
        step_no++;
        e.step  = step_no;
        e.valid = ev;
        e.idx   = ei;
        e.busy  = eb;
        exp_q.push_back(e);
    endtask

    task automatic check_cleared(input string tag);
        checks++;
        assert (grant_valid === 1'b0) else begin
            failures++;
            $error("FAIL %s grant_valid observed=%0b expected=0", tag, grant_valid);
        end
        checks++;
        assert (grant_idx === 4'd0) else begin
            failures++;
            $error("FAIL %s grant_idx observed=%0d expected=0", tag, grant_idx);
        end
        checks++;
        assert (grant_onehot === 16'h0000) else begin
            failures++;
            $error("FAIL %s grant_onehot observed=%h expected=0000", tag, grant_onehot);
        end
        checks++;
        assert (busy === 1'b0) else begin
            failures++;
            $error("FAIL %s busy observed=%0b expected=0", tag, busy);
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (exp_q.size() != 0) begin
            cur    = exp_q.pop_front();
            exp_oh = cur.valid ? (16'h0001 << cur.idx) : 16'h0000;
            checks++;
            assert (grant_valid === cur.valid) else begin
                failures++;
                $error("FAIL step%0d grant_valid observed=%0b expected=%0b", cur.step, grant_valid, cur.valid);
            end
            checks++;
            assert (grant_idx === cur.idx) else begin
                failures++;
                $error("FAIL step%0d grant_idx observed=%0d expected=%0d", cur.step, grant_idx, cur.idx);
            end
            checks++;
            assert (grant_onehot === exp_oh) else begin
                failures++;
                $error("FAIL step%0d grant_onehot observed=%h expected=%h", cur.step, grant_onehot, exp_oh);
            end
            checks++;
            assert (busy === cur.busy) else begin
                failures++;
                $error("FAIL step%0d busy observed=%0b expected=%0b", cur.step, busy, cur.busy);
            end
            $display("step%0d req=%h rel=%0b valid=%0b idx=%0d onehot=%h busy=%0b",
                     cur.step, req, bus_release, grant_valid, grant_idx, grant_onehot, busy);
        end
    end

    initial begin
        req         = 16'h0000;
        bus_release = 1'b0;
        clear       = 1'b0;
        #1 clear = 1'b1;
        #2 check_cleared("reset");
        @(negedge clock);
        clear = 1'b0;

        // Single requester, release after three owned cycles; ptr moves to 1.
        for (int i = 0; i < 3; i++) drive(16'h0001, 1'b0, 1'b1, 4'd0, 1'b1);
        drive(16'h0001, 1'b1, 1'b0, 4'd0, 1'b1);
        drive(16'h0000, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(16'h0003, 1'b0, 1'b1, 4'd1, 1'b1);
        drive(16'h0003, 1'b1, 1'b0, 4'd1, 1'b1);
        drive(16'h0000, 1'b0, 1'b0, 4'd1, 1'b0);

        // Clear pulse restores source-0 priority; then rotation 0,9,15,0.
        @(negedge clock);
        clear = 1'b1;
        #1 check_cleared("clear_idle");
        @(negedge clock);
        clear = 1'b0;
        order[0] = 4'd0;
        order[1] = 4'd9;
        order[2] = 4'd15;
        order[3] = 4'd0;
        for (int g = 0; g < 4; g++) begin
            drive(16'h8201, 1'b0, 1'b1, order[g], 1'b1);
            drive(16'h8201, 1'b0, 1'b1, order[g], 1'b1);
            drive(16'h8201, 1'b1, 1'b0, order[g], 1'b1);
            drive(16'h8201, 1'b0, 1'b0, order[g], 1'b0);
        end

        // Release outside OWNED has no effect.
        drive(16'h0000, 1'b1, 1'b0, 4'd0, 1'b0);

        // Forced hand-over after four owned cycles between sources 1 and 2.
        for (int s = 1; s <= 2; s++) begin
            for (int i = 0; i < 4; i++) drive(16'h0006, 1'b0, 1'b1, 4'(s), 1'b1);
            drive(16'h0006, 1'b0, 1'b0, 4'(s), 1'b1);
            drive(16'h0006, 1'b0, 1'b0, 4'(s), 1'b0);
        end

        // Lone requester keeps the bus well past the hold limit.
        for (int i = 0; i < 22; i++) drive(16'h0010, 1'b0, 1'b1, 4'd4, 1'b1);
        drive(16'h0010, 1'b1, 1'b0, 4'd4, 1'b1);
        drive(16'h0000, 1'b0, 1'b0, 4'd4, 1'b0);

        // Release coinciding with forced hand-over: one TURN, ptr advances once.
        for (int i = 0; i < 4; i++) drive(16'h0060, 1'b0, 1'b1, 4'd5, 1'b1);
        drive(16'h0060, 1'b1, 1'b0, 4'd5, 1'b1);
        drive(16'h0060, 1'b0, 1'b0, 4'd5, 1'b0);
        drive(16'h0060, 1'b0, 1'b1, 4'd6, 1'b1);
        drive(16'h0060, 1'b1, 1'b0, 4'd6, 1'b1);
        drive(16'h0000, 1'b0, 1'b0, 4'd6, 1'b0);

        // Clear while source 7 owns: outputs drop at once, source 0 then wins.
        drive(16'h0080, 1'b0, 1'b1, 4'd7, 1'b1);
        drive(16'h0080, 1'b0, 1'b1, 4'd7, 1'b1);
        @(posedge clock);
        #2;
        clear = 1'b1;
        req   = 16'h0000;
        #1 check_cleared("clear_owned");
        @(negedge clock);
        clear = 1'b0;
        drive(16'h0081, 1'b0, 1'b1, 4'd0, 1'b1);
        drive(16'h0081, 1'b1, 1'b0, 4'd0, 1'b1);
        drive(16'h0000, 1'b0, 1'b0, 4'd0, 1'b0);

        // Owner 5 drops its request; next decision wraps from ptr 6 to source 0.
        drive(16'h0021, 1'b0, 1'b1, 4'd5, 1'b1);
        drive(16'h0001, 1'b0, 1'b0, 4'd5, 1'b1);
        drive(16'h0021, 1'b0, 1'b0, 4'd5, 1'b0);
        drive(16'h0021, 1'b0, 1'b1, 4'd0, 1'b1);
        drive(16'h0000, 1'b0, 1'b0, 4'd0, 1'b1);
        drive(16'h0000, 1'b0, 1'b0, 4'd0, 1'b0);

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clock);
        #3;
        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL drain pending observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
